// File: rtl/fht_but_ctrl.sv
// Address sequencer for a radix-2 Hartley butterfly across all log2(N) stages.
// Define FHT_CTRL_BITREV_EN to bit-reverse stage-0 read addresses (natural-order input).
module fht_but_ctrl #(
    parameter int N_LOG2  = 3,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 2
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iSTART,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic                       oRD_EN,
    output logic [N_LOG2-1:0]          oRD_ADDR_0,
    output logic [N_LOG2-1:0]          oRD_ADDR_1,
    output logic [N_LOG2-1:0]          oRD_ADDR_2,
    output logic [N_LOG2-2:0]          oCOEF_ADDR,
    output logic                       oWR_EN,
    output logic [N_LOG2-1:0]          oWR_ADDR_0,
    output logic [N_LOG2-1:0]          oWR_ADDR_1,
    output logic                       oBANK,
    output logic [$clog2(N_LOG2)-1:0]  oSTAGE
);
    localparam int PIPE_LAT = RD_LAT + BUT_LAT + 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int JW = N_LOG2 - 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [N_LOG2-1:0] x0;
        logic [N_LOG2-1:0] x1;
        logic [N_LOG2-1:0] x2;
        logic [JW-1:0]     coef;
    } bfly_t;

    state_t            state;
    logic [SW-1:0]     stage, nxt_s;
    logic [JW-1:0]     idx, nxt_j;
    logic [DW-1:0]     dcnt;
    logic [N_LOG2-1:0] x0_q, nat0, nat1;
    logic              issue, dlast, slast;
    bfly_t             bf, rd;

    logic              dl_en [PIPE_LAT];
    logic [N_LOG2-1:0] dl_a0 [PIPE_LAT];
    logic [N_LOG2-1:0] dl_a1 [PIPE_LAT];

    // Butterfly j of stage s: k = low s bits of j, group base = j with a 0 inserted at bit s.
    function automatic bfly_t bfly(input logic [SW-1:0] s, input logic [JW-1:0] j);
        logic [N_LOG2-1:0] h, k, base, jj;
        bfly_t r;
        jj     = {1'b0, j};
        h      = N_LOG2'(1) << s;
        k      = jj & (h - N_LOG2'(1));
        base   = (jj >> s) << (s + 1);
        r.x0   = base + k;
        r.x1   = base + h + k;
        r.x2   = base + h + ((h - k) & (h - N_LOG2'(1)));
        r.coef = JW'(k << (JW - int'(s)));
        return r;
    endfunction

`ifdef FHT_CTRL_BITREV_EN
    function automatic logic [N_LOG2-1:0] brev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        for (int unsigned i = 0; i < N_LOG2; i++)
            r[i] = a[N_LOG2-1-i];
        return r;
    endfunction
`endif

    always_comb begin
        nxt_j = '0;
        nxt_s = '0;
        if (state == S_RUN) begin
            nxt_j = idx + JW'(1);
            nxt_s = stage;
        end else if (state == S_DRAIN) begin
            nxt_s = stage + SW'(1);
        end
        bf = bfly(nxt_s, nxt_j);
        rd = bf;
`ifdef FHT_CTRL_BITREV_EN
        if (nxt_s == '0) begin
            rd.x0 = brev(bf.x0);
            rd.x1 = brev(bf.x1);
            rd.x2 = brev(bf.x2);
        end
`endif
        dlast = (dcnt == DW'(PIPE_LAT - 1));
        slast = (stage == SW'(N_LOG2 - 1));
        issue = (state == S_IDLE && iSTART) ||
                (state == S_RUN && idx != '1) ||
                (state == S_DRAIN && dlast && !slast);
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state      <= S_IDLE;
            stage      <= '0;
            idx        <= '0;
            dcnt       <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oRD_EN     <= 1'b0;
            oRD_ADDR_0 <= '0;
            oRD_ADDR_1 <= '0;
            oRD_ADDR_2 <= '0;
            oCOEF_ADDR <= '0;
            x0_q       <= '0;
            nat0       <= '0;
            nat1       <= '0;
        end else begin
            oRD_EN     <= issue;
            oDONE      <= 1'b0;
            oRD_ADDR_0 <= x0_q;
            if (issue) begin
                stage      <= nxt_s;
                idx        <= nxt_j;
                oRD_ADDR_1 <= rd.x1;
                oRD_ADDR_2 <= rd.x2;
                oCOEF_ADDR <= rd.coef;
                x0_q       <= rd.x0;
                nat0       <= bf.x0;
                nat1       <= bf.x1;
            end
            case (state)
                S_IDLE: if (iSTART) begin
                    state <= S_RUN;
                    oBUSY <= 1'b1;
                end
                S_RUN: if (idx == '1) begin
                    state <= S_DRAIN;
                    dcnt  <= '0;
                end
                S_DRAIN: begin
                    if (!dlast) begin
                        dcnt <= dcnt + DW'(1);
                    end else if (slast) begin
                        state <= S_DONE;
                        oBUSY <= 1'b0;
                        oDONE <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write addresses ride alongside the read strobe, always in natural order.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dl_en[i] <= 1'b0;
                dl_a0[i] <= '0;
                dl_a1[i] <= '0;
            end
        end else begin
            dl_en[0] <= oRD_EN;
            dl_a0[0] <= nat0;
            dl_a1[0] <= nat1;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a0[i] <= dl_a0[i-1];
                dl_a1[i] <= dl_a1[i-1];
            end
        end
    end

    assign oWR_EN     = dl_en[PIPE_LAT-1];
    assign oWR_ADDR_0 = dl_a0[PIPE_LAT-1];
    assign oWR_ADDR_1 = dl_a1[PIPE_LAT-1];
    assign oSTAGE     = stage;
    assign oBANK      = stage[0];
endmodule

// File: tb/tb_fht_but_ctrl.sv
// Scoreboard bench for fht_but_ctrl at N_LOG2=3: read/x0/write sequences, timing, reset and start handling.
module tb_fht_but_ctrl;
    localparam int L  = 3;
    localparam int N  = 8;
    localparam int P  = 4;
    localparam int SW = 2;

    logic          iCLK = 1'b0, iRESET = 1'b1, iSTART = 1'b0;
    logic          oBUSY, oDONE, oRD_EN, oWR_EN, oBANK;
    logic [L-1:0]  oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;
    logic [L-2:0]  oCOEF_ADDR;
    logic [SW-1:0] oSTAGE;
    logic [25:0]   outs;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
        int bank;
        int stage;
    } ev_t;

    ev_t rq[$];
    ev_t wq[$];
    ev_t x0q[$];

    fht_but_ctrl #(.N_LOG2(L), .RD_LAT(1), .BUT_LAT(2)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE), .oRD_EN(oRD_EN),
        .oRD_ADDR_0(oRD_ADDR_0), .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2),
        .oCOEF_ADDR(oCOEF_ADDR), .oWR_EN(oWR_EN),
        .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1),
        .oBANK(oBANK), .oSTAGE(oSTAGE)
    );

    assign outs = {oBUSY, oDONE, oRD_EN, oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR,
                   oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oBANK, oSTAGE};

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic int rev(input int x);
        int r = 0;
        for (int i = 0; i < L; i++)
            if (((x >> i) & 1) != 0) r = r | (1 << (L - 1 - i));
        return r;
    endfunction

    // Expected reads/x0/writes for a start sampled at the end of cycle t0.
    task automatic build_model(input int t0);
        ev_t e;
        int h, b, x0, x1, x2, rc, n;
        rq.delete(); wq.delete(); x0q.delete();
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            n = 0;
            for (int g = 0; g < N / (2 * h); g++) begin
                for (int k = 0; k < h; k++) begin
                    b  = g * 2 * h;
                    x0 = b + k;
                    x1 = b + h + k;
                    x2 = b + h + ((h - k) % h);
                    rc = t0 + 1 + s * (N / 2 + P) + n;
                    wq.push_back('{rc + P, x0, x1, 0, 0, 0});
`ifdef FHT_CTRL_BITREV_EN
                    if (s == 0) begin
                        x0 = rev(x0); x1 = rev(x1); x2 = rev(x2);
                    end
`endif
                    e = '{rc, x1, x2, k << (L - 1 - s), s % 2, s};
                    rq.push_back(e);
                    x0q.push_back('{rc + 1, x0, 0, 0, 0, 0});
                    n++;
                end
            end
        end
    endtask

    task automatic test_reset();
        iRESET = 1'b1;
        repeat (3) @(negedge iCLK);
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        iRESET = 1'b0;
        @(negedge iCLK);
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL idle_after_release: got %h, want 0", outs);
        end
    endtask

    task automatic test_full_transform(input string name, input bit poke);
        int t0, done_at, c;
        bit exp_rd, exp_wr, exp_busy;
        ev_t e;
        @(negedge iCLK);
        iSTART = 1'b1;
        t0 = cyc;
        build_model(t0);
        done_at = t0 + L * (N / 2 + P) + 1;
        c = t0;
        for (int i = 0; i < 100 && c < done_at; i++) begin
            @(negedge iCLK);
            c = cyc;
            iSTART = poke && (c == t0 + 3 || c == t0 + 7);
            exp_busy = (c > t0) && (c < done_at);
            n_cmp++;
            if (oBUSY !== exp_busy) begin
                n_err++;
                $display("FAIL %s busy @%0d: got %b, want %b", name, c - t0, oBUSY, exp_busy);
            end
            exp_rd = rq.size() > 0 && rq[0].cyc == c;
            n_cmp++;
            if (oRD_EN !== exp_rd) begin
                n_err++;
                $display("FAIL %s rd_en @%0d: got %b, want %b", name, c - t0, oRD_EN, exp_rd);
            end
            if (exp_rd) begin
                e = rq.pop_front();
                n_cmp++;
                if (int'(oRD_ADDR_1) != e.a || int'(oRD_ADDR_2) != e.b || int'(oCOEF_ADDR) != e.c ||
                    int'(oBANK) != e.bank || int'(oSTAGE) != e.stage) begin
                    n_err++;
                    $display("FAIL %s rd @%0d: got x1=%0d x2=%0d coef=%0d bank=%0d stage=%0d, want %0d %0d %0d %0d %0d",
                             name, c - t0, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR, oBANK, oSTAGE,
                             e.a, e.b, e.c, e.bank, e.stage);
                end
            end
            if (x0q.size() > 0 && x0q[0].cyc == c) begin
                e = x0q.pop_front();
                n_cmp++;
                if (int'(oRD_ADDR_0) != e.a) begin
                    n_err++;
                    $display("FAIL %s x0 @%0d: got %0d, want %0d", name, c - t0, oRD_ADDR_0, e.a);
                end
            end
            exp_wr = wq.size() > 0 && wq[0].cyc == c;
            n_cmp++;
            if (oWR_EN !== exp_wr) begin
                n_err++;
                $display("FAIL %s wr_en @%0d: got %b, want %b", name, c - t0, oWR_EN, exp_wr);
            end
            if (exp_wr) begin
                e = wq.pop_front();
                n_cmp++;
                if (int'(oWR_ADDR_0) != e.a || int'(oWR_ADDR_1) != e.b) begin
                    n_err++;
                    $display("FAIL %s wr @%0d: got y0=%0d y1=%0d, want %0d %0d",
                             name, c - t0, oWR_ADDR_0, oWR_ADDR_1, e.a, e.b);
                end
            end
            n_cmp++;
            if (oDONE !== (c == done_at)) begin
                n_err++;
                $display("FAIL %s done @%0d: got %b, want %b", name, c - t0, oDONE, c == done_at);
            end
        end
        iSTART = 1'b0;
        n_cmp++;
        if (c < done_at || rq.size() + wq.size() + x0q.size() != 0) begin
            n_err++;
            $display("FAIL %s leftover: got %0d pending events at cycle %0d, want 0 by %0d",
                     name, rq.size() + wq.size() + x0q.size(), c - t0, done_at - t0);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        @(negedge iCLK);
        iSTART = 1'b1;
        t0 = cyc;
        @(negedge iCLK);
        iSTART = 1'b0;
        for (int i = 0; i < 20 && cyc < t0 + 10; i++) @(negedge iCLK);
        n_cmp++;
        if (oBUSY !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy_before_reset: got %b, want 1", oBUSY);
        end
        iRESET = 1'b1;
        #1;
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h, want 0", outs);
        end
        repeat (2) @(negedge iCLK);
        iRESET = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iCLK);
            n_cmp++;
            if ({oDONE, oBUSY, oRD_EN, oWR_EN} !== 4'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet @%0d: got done/busy/rd/wr=%b, want 0000",
                         i, {oDONE, oBUSY, oRD_EN, oWR_EN});
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_transform("plain", 1'b0);
        test_full_transform("start_while_busy", 1'b1);
        test_reset_mid();
        test_full_transform("after_reset", 1'b0);
        test_full_transform("back_to_back", 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fht_but_ctrl.md
# fht_but_ctrl

Sequencer for the radix-2 Hartley butterfly (`fht_but`) in an N-point FHT. On a start pulse it walks all log2(N) stages and issues, every cycle, the read addresses for the butterfly operands x0/x1/x2 and the twiddle ROM address. It also issues the delayed write-back addresses for y0/y1. It sits between the ping-pong sample RAM, the sin/cos ROM and the single butterfly instance.

## Interface
- `N_LOG2`, 3: log2 of transform length N; legal range 2..12.
- `RD_LAT`, 1: RAM/ROM read latency in cycles.
- `BUT_LAT`, 2: butterfly latency from x1/x2/coef at its inputs to y0/y1 valid. x0 is sampled one cycle after x1/x2.
- `iCLK` in 1: single clock, rising edge.
- `iRESET` in 1: asynchronous, active-high reset.
- `iSTART` in 1: one-cycle start request.
- `oBUSY` out 1: high from the first cycle after an accepted start until `oDONE`.
- `oDONE` out 1: one-cycle pulse when the transform is complete.
- `oRD_EN` out 1: read strobe, valid with `oRD_ADDR_1`, `oRD_ADDR_2` and `oCOEF_ADDR`.
- `oRD_ADDR_0` out N_LOG2: x0 address. Issued one cycle after the matching x1/x2 addresses.
- `oRD_ADDR_1`, `oRD_ADDR_2` out N_LOG2: x1 and x2 addresses.
- `oCOEF_ADDR` out N_LOG2-1: twiddle ROM index. The ROM holds cos/sin of 2π·idx/N.
- `oWR_EN` out 1: write strobe for y0/y1.
- `oWR_ADDR_0`, `oWR_ADDR_1` out N_LOG2: y0 and y1 write addresses.
- `oBANK` out 1: read bank of the current stage; the write bank is `~oBANK`.
- `oSTAGE` out ceil(log2(N_LOG2)): current stage index s.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE + `iSTART`: go to RUN with s=0, g=0, k=0.
  - RUN: issue one butterfly per cycle.
  - DRAIN: wait PIPE_LAT = RD_LAT+BUT_LAT+1 cycles so no write is pending.
  - After DRAIN: go to RUN with s+1, or to DONE after the last stage.
  - DONE: one cycle, then IDLE.
- **Stage s:** H = 2^s; group base b = g·2H, g = 0..N/(2H)-1; k = 0..H-1. Each stage issues exactly N/2 butterflies, with k innermost.
- **Addresses per butterfly:**
  - x0 = b+k
  - x1 = b+H+k
  - x2 = b+H+((H−k) mod H)
  - coef = k << (N_LOG2−1−s)
  - y0 → b+k, y1 → b+H+k
- **Banks:** stage s reads bank s mod 2 and writes the opposite bank. The final result sits in bank N_LOG2 mod 2.
- **Write delay:** write addresses are the x0/x1 addresses delayed through a PIPE_LAT-deep shift register that travels with `oRD_EN`.
- `iSTART` outside IDLE is ignored.
- All address arithmetic is unsigned modulo 2^N_LOG2. Counters wrap only at stage end.

## Timing
- **Reset:** while `iRESET` is high, all outputs are 0, the FSM is in IDLE and the delay line is cleared. This applies mid-transform too: pending writes are discarded and no `oDONE` is produced.
- **First read:** `iSTART` sampled high at edge t0 → first `oRD_EN` in cycle t0+1.
- **x0 address:** `oRD_ADDR_0` for issue cycle t is presented in cycle t+1.
- **Write-back:** the write for the butterfly issued at t appears at t+PIPE_LAT (default t+4).
- **Per stage:** N/2 RUN cycles plus PIPE_LAT DRAIN cycles. `oSTAGE` and `oBANK` change on the first RUN cycle of the next stage.
- **Completion:** `oDONE` is asserted in the cycle after the last write of the last stage. `oBUSY` drops in that same cycle.
- **Total:** from `iSTART` to `oDONE` is N_LOG2·(N/2+PIPE_LAT)+1 cycles. The default configuration gives 3·(4+4)+1 = 25.

## Configuration
- `FHT_CTRL_BITREV_EN`:
  - Defined: in stage 0 only, all three read addresses are bit-reversed over N_LOG2 bits. The RAM can then hold samples in natural order.
  - Undefined: no reversal; the input must already be stored in bit-reversed order.
  - Write addresses are never reversed in either case.

## Test plan
- **Stage 0 sequence (N_LOG2=3, BITREV off):** pulse `iSTART` → RUN issues (x0,x1,x2) = (0,1,1), (2,3,3), (4,5,5), (6,7,7), all with coef 0 and `oBANK`=0.
- **Stage 2 sequence (N_LOG2=3):** RUN issues (0,4,4,c0), (1,5,7,c1), (2,6,6,c2), (3,7,5,c3) with `oBANK`=0. Stage 1 issues (0,2,2,c0), (1,3,3,c2), (4,6,6,c0), (5,7,7,c2).
- **Write-back alignment:** each `oWR_EN` appears exactly 4 cycles after its `oRD_EN`, with matching y0/y1 addresses. No read of stage s+1 occurs before the last write of stage s. `oDONE` arrives 25 cycles after `iSTART`.
- **Reset and start handling:**
  - Assert `iRESET` in cycle 10 of a run → all outputs 0 immediately and no `oDONE`.
  - A new `iSTART` after release runs a full, correct 25-cycle transform.
  - An `iSTART` pulsed while `oBUSY` is high has no effect on the sequence.
- **BITREV on (`FHT_CTRL_BITREV_EN`, N_LOG2=3):** stage 0 first butterfly reads (0,4,4), second reads (2,6,6). Stage 0 writes still go to (0,1), (2,3).
